gmii_tx_framer: RTL and testbench
=================================

# gmii_tx_framer

Transmit framing stage that feeds `gmii2rgmii`. Accepts a raw payload byte stream with a valid/ready/last handshake and produces a complete Ethernet frame on GMII: 7-byte preamble, SFD, payload, zero padding to the minimum length, CRC-32 FCS, and the enforced inter-frame gap. Sits between the UDP/IP packet builder and the RGMII DDR output stage, all in the 125 MHz `gmii_clk` domain.

## Interface
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before SFD.
- `MIN_FRAME`, 60: minimum payload+pad bytes before FCS; 0 disables padding.
- `IFG_CYCLES`, 12: idle cycles with `gmii_tx_en`=0 after the last FCS byte.
- `gmii_clk` in 1: transmit clock; everything is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_tx_data` in 8: payload byte.
- `s_tx_valid` in 1: payload byte valid.
- `s_tx_last` in 1: marks the final payload byte.
- `s_tx_err` in 1: marks a corrupt byte; it is flagged on GMII.
- `s_tx_ready` out 1: byte accepted when `s_tx_valid` and `s_tx_ready` are both high.
- `gmii_tx_en` out 1: GMII transmit enable, registered.
- `gmii_tx_err` out 1: GMII transmit error, registered.
- `gmii_tx_data` out 8: GMII transmit byte, registered.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- IDLE: `s_tx_ready`=0. Moves to PREAMBLE when `s_tx_valid`=1 is sampled. No byte is consumed at this point.
- PREAMBLE: outputs 0x55 for `PREAMBLE_LEN` cycles, then moves to SFD.
- SFD: outputs 0xD5. CRC register is loaded with 0xFFFFFFFF. Moves to DATA.
- DATA: `s_tx_ready`=1, decoded from the state register only and never dependent on `s_tx_valid`.
  - Each accepted byte goes to `gmii_tx_data` on the next edge with `gmii_tx_en`=1, `gmii_tx_err`=`s_tx_err`, and is folded into the CRC.
  - A byte counter (16 bit, saturating) counts accepted bytes.
  - On an accepted `s_tx_last`: go to PAD if count < `MIN_FRAME`, otherwise go to FCS.
- Underrun: `s_tx_valid`=0 while in DATA.
  - Output one cycle of `gmii_tx_en`=1, `gmii_tx_err`=1, data 0x00.
  - Then go straight to IFG, skipping PAD and FCS.
  - The upstream source must discard the rest of its frame.
- PAD: outputs 0x00 (folded into the CRC) until count reaches `MIN_FRAME`, then moves to FCS.
- FCS: outputs ~CRC over 4 cycles, LSB byte first. CRC-32 is reflected, polynomial 0x04C11DB7 (reflected form 0xEDB88320). Moves to IFG.
- IFG: `gmii_tx_en`=0 and `gmii_tx_data`=0x00 for `IFG_CYCLES` cycles, then returns to IDLE.
- `s_tx_err` never aborts the frame; it only sets `gmii_tx_err` on that byte's cycle.

## Timing
- Reset values: state IDLE, `gmii_tx_en`=0, `gmii_tx_err`=0, `gmii_tx_data`=0x00, `s_tx_ready`=0, `busy`=0, all counters 0.
- Reset mid-frame takes effect immediately (asynchronous). The frame is truncated and no FCS is sent.
- Let T be the edge where IDLE samples valid.
  - 0x55 appears after edges T+1 .. T+PREAMBLE_LEN.
  - 0xD5 appears after edge T+PREAMBLE_LEN+1.
  - Payload byte k appears after edge T+PREAMBLE_LEN+2+k.
- `gmii_tx_en` stays high for exactly PREAMBLE_LEN + 1 + max(N, MIN_FRAME) + 4 cycles for an N-byte payload.
- Back-to-back frames: the earliest next preamble comes `IFG_CYCLES`+1 cycles after the last FCS byte, because IDLE costs one cycle.
- `s_tx_last` with N=1 is legal.
- A frame longer than 65535 bytes is out of scope; the counter saturates.

## Structure
- Package `eth_tx_pkg`:
  - state enum `tx_state_e`
  - constants: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC_POLY_REFL=32'hEDB88320.
- Sub-module `crc32_d8`: purely combinational next-CRC for 8 data bits. Inputs are crc_in[31:0] and data[7:0]; output is crc_out[31:0]. It is instantiated once.

## Test plan
- Payload "123456789" (0x31..0x39) with `MIN_FRAME`=0: 7×0x55, 0xD5, 9 payload bytes, then FCS 0x26 0x39 0xF4 0xCB. `gmii_tx_en` is high for 21 cycles.
- 10-byte payload 0x01..0x0A with `MIN_FRAME`=60: payload, then 50 bytes of 0x00, then 4 FCS bytes matching the reference model. `gmii_tx_en` is high for 72 cycles.
- Two 64-byte frames presented back-to-back: exactly 13 cycles with `gmii_tx_en`=0 between the last FCS byte and the next 0x55.
- `s_tx_valid` dropped after the 5th byte of a 20-byte frame: one cycle with `gmii_tx_err`=1 and data 0x00, then 12 idle cycles, then IDLE. No FCS is sent.
- `s_tx_err`=1 on byte 3 of 64: `gmii_tx_err` is high only in that byte's output cycle, and the frame and FCS still complete.
- `rst` asserted during PAD: all outputs are 0 immediately. After release, a fresh frame is sent with a correct preamble and FCS.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit framer.
// Imported by the framer top and the CRC helper.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one data byte.
// Bit-serial form unrolled over eight iterations.
module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC_POLY_REFL;
            else      c = c >> 1;
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, pad, FCS and IFG.
// All outputs except s_tx_ready and busy are registered.
module gmii_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       gmii_clk,
    input  logic       rst,
    input  logic [7:0] s_tx_data,
    input  logic       s_tx_valid,
    input  logic       s_tx_last,
    input  logic       s_tx_err,
    output logic       s_tx_ready,
    output logic       gmii_tx_en,
    output logic       gmii_tx_err,
    output logic [7:0] gmii_tx_data,
    output logic       busy
);

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [16:0] MIN_W    = 17'(MIN_FRAME);

    tx_state_e   state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [15:0] byte_cnt, byte_cnt_d;
    logic [31:0] crc, crc_d;
    logic        en_d, err_d;
    logic [7:0]  data_d;

    logic [7:0]  crc_data;
    logic [31:0] crc_nxt;
    logic [31:0] crc_inv;
    logic [15:0] cnt_inc;

    assign crc_data = (state == ST_PAD) ? 8'h00 : s_tx_data;
    assign crc_inv  = ~crc;
    assign cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt
                                             : byte_cnt + 16'd1;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (crc_data),
        .crc_out (crc_nxt)
    );

    assign s_tx_ready = (state == ST_DATA);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        byte_cnt_d = byte_cnt;
        crc_d      = crc;
        en_d       = 1'b0;
        err_d      = 1'b0;
        data_d     = 8'h00;
        unique case (state)
            ST_IDLE: begin
                cnt_d      = 8'd0;
                byte_cnt_d = 16'd0;
                if (s_tx_valid) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                en_d   = 1'b1;
                data_d = PREAMBLE_BYTE;
                if (cnt == PRE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SFD;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            ST_SFD: begin
                en_d    = 1'b1;
                data_d  = SFD_BYTE;
                crc_d   = CRC_INIT;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                en_d = 1'b1;
                if (s_tx_valid) begin
                    data_d     = s_tx_data;
                    err_d      = s_tx_err;
                    crc_d      = crc_nxt;
                    byte_cnt_d = cnt_inc;
                    if (s_tx_last) begin
                        if ({1'b0, cnt_inc} < MIN_W) state_d = ST_PAD;
                        else                         state_d = ST_FCS;
                    end
                end else begin
                    // Underrun: poison the frame and skip pad/FCS.
                    err_d   = 1'b1;
                    state_d = ST_IFG;
                end
            end
            ST_PAD: begin
                en_d       = 1'b1;
                crc_d      = crc_nxt;
                byte_cnt_d = cnt_inc;
                if ({1'b0, cnt_inc} >= MIN_W) state_d = ST_FCS;
            end
            ST_FCS: begin
                en_d = 1'b1;
                unique case (cnt[1:0])
                    2'd0: data_d = crc_inv[7:0];
                    2'd1: data_d = crc_inv[15:8];
                    2'd2: data_d = crc_inv[23:16];
                    2'd3: data_d = crc_inv[31:24];
                endcase
                if (cnt[1:0] == 2'd3) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IFG;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            ST_IFG: begin
                if (cnt == IFG_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            byte_cnt     <= 16'd0;
            crc          <= 32'd0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_err  <= 1'b0;
            gmii_tx_data <= 8'h00;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            byte_cnt     <= byte_cnt_d;
            crc          <= crc_d;
            gmii_tx_en   <= en_d;
            gmii_tx_err  <= err_d;
            gmii_tx_data <= data_d;
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer (padded and unpadded instances).
// Expected GMII bytes are queued at drive time and popped per tx_en cycle.
module tb_gmii_tx_framer;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_err;
    logic       sel;

    logic       en1, err1, rdy1, busy1;
    logic [7:0] data1;
    logic       en0, err0, rdy0, busy0;
    logic [7:0] data0;

    exp_t       q1[$], q0[$];
    int         len1[$], len0[$];
    logic [7:0] pl[$];

    int nvec = 0;
    int nerr = 0;
    int run1 = 0, run0 = 0, gap1 = 0;
    bit gap_armed = 0;

    gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_CYCLES(12)) dut (
        .gmii_clk     (clk),
        .rst          (rst),
        .s_tx_data    (s_data),
        .s_tx_valid   (s_valid & sel),
        .s_tx_last    (s_last),
        .s_tx_err     (s_err),
        .s_tx_ready   (rdy1),
        .gmii_tx_en   (en1),
        .gmii_tx_err  (err1),
        .gmii_tx_data (data1),
        .busy         (busy1)
    );

    gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_CYCLES(12)) dut0 (
        .gmii_clk     (clk),
        .rst          (rst),
        .s_tx_data    (s_data),
        .s_tx_valid   (s_valid & ~sel),
        .s_tx_last    (s_last),
        .s_tx_err     (s_err),
        .s_tx_ready   (rdy0),
        .gmii_tx_en   (en0),
        .gmii_tx_err  (err0),
        .gmii_tx_data (data0),
        .busy         (busy0)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic put(input bit s, input exp_t e);
        if (s) q1.push_back(e);
        else   q0.push_back(e);
    endtask

    task automatic put_len(input bit s, input int n);
        if (s) len1.push_back(n);
        else   len0.push_back(n);
    endtask

    task automatic push_frame(input bit s, input int erri, input int stop,
                              input bit ovr, input logic [31:0] fcs_v);
        int          minf;
        int          n;
        logic [31:0] c;
        minf = s ? 60 : 0;
        n    = 0;
        c    = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) put(s, {1'b0, 8'h55});
        put(s, {1'b0, 8'hD5});
        for (int i = 0; i < pl.size(); i++) begin
            if (i == stop) break;
            put(s, {(i == erri), pl[i]});
            c = crc_step(c, pl[i]);
            n++;
        end
        if (stop >= 0) begin
            put(s, {1'b1, 8'h00});
            put_len(s, 8 + n + 1);
        end else begin
            while (n < minf) begin
                put(s, {1'b0, 8'h00});
                c = crc_step(c, 8'h00);
                n++;
            end
            c = ovr ? fcs_v : ~c;
            for (int b = 0; b < 4; b++) put(s, {1'b0, c[8*b +: 8]});
            put_len(s, 8 + n + 4);
        end
    endtask

    task automatic wait_rdy(input bit s);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(s ? rdy1 : rdy0) && t < 500);
        if (!(s ? rdy1 : rdy0)) chk("rdy_timeout", {31'b0, s ? rdy1 : rdy0}, 1);
    endtask

    task automatic send(input bit s, input int erri, input int stop,
                        input bit ovr, input logic [31:0] fcs_v);
        push_frame(s, erri, stop, ovr, fcs_v);
        sel = s;
        for (int i = 0; i < pl.size(); i++) begin
            if (i == stop) break;
            s_data  = pl[i];
            s_err   = (i == erri);
            s_last  = (i == pl.size() - 1);
            s_valid = 1'b1;
            wait_rdy(s);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_err   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy0 || busy1 || q1.size() != 0 || q0.size() != 0)
                   && t < 3000);
        if (busy0 || busy1) chk("drain_timeout", {30'b0, busy1, busy0}, 0);
    endtask

    task automatic fill(input int n, input bit rnd, input logic [7:0] base);
        pl.delete();
        for (int i = 0; i < n; i++)
            pl.push_back(rnd ? 8'($urandom_range(0, 255)) : base + 8'(i));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run1 = 0;
        end else if (en1) begin
            if (run1 == 0 && gap_armed) begin
                chk("b2b_gap", gap1, 13);
                gap_armed = 0;
            end
            run1++;
            if (q1.size() == 0) begin
                chk("spurious_en", {31'b0, en1}, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("byte", {23'b0, err1, data1}, {23'b0, e});
            end
        end else begin
            if (run1 != 0) begin
                if (len1.size() != 0) chk("en_len", run1, len1.pop_front());
                else                  chk("en_len_spur", run1, 0);
                run1 = 0;
                gap1 = 0;
            end
            gap1++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            run0 = 0;
        end else if (en0) begin
            run0++;
            if (q0.size() == 0) begin
                chk("spurious_en0", {31'b0, en0}, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("byte0", {23'b0, err0, data0}, {23'b0, e});
            end
        end else if (run0 != 0) begin
            if (len0.size() != 0) chk("en_len0", run0, len0.pop_front());
            else                  chk("en_len0_spur", run0, 0);
            run0 = 0;
        end
    end

    initial begin
        int t, k;
        rst     = 1'b1;
        sel     = 1'b1;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_err   = 1'b0;
        #1;
        chk("reset1", {20'b0, en1, err1, data1, rdy1, busy1}, 0);
        chk("reset0", {20'b0, en0, err0, data0, rdy0, busy0}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fill(9, 0, 8'h31);
        send(0, -1, -1, 1, 32'hCBF43926);
        drain();

        fill(10, 0, 8'h01);
        send(1, -1, -1, 0, 32'h0);
        drain();

        fill(64, 1, 8'h00);
        send(1, -1, -1, 0, 32'h0);
        gap_armed = 1;
        fill(64, 1, 8'h00);
        send(1, -1, -1, 0, 32'h0);
        drain();
        chk("gap_seen", {31'b0, gap_armed}, 0);

        fill(20, 1, 8'h00);
        send(1, -1, 5, 0, 32'h0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!err1 && t < 50);
        chk("urun_err", {31'b0, err1}, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (en1) chk("ifg_en", {31'b0, en1}, 0);
        end while (busy1 && k < 100);
        chk("ifg_len", k, 12);
        drain();

        fill(64, 1, 8'h00);
        send(1, 2, -1, 0, 32'h0);
        drain();

        fill(10, 1, 8'h00);
        send(1, -1, -1, 0, 32'h0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid", {20'b0, en1, err1, data1, rdy1, busy1}, 0);
        q1.delete();
        len1.delete();
        gap_armed = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fill(16, 1, 8'h00);
        send(1, -1, -1, 0, 32'h0);
        drain();

        repeat (4) @(negedge clk);
        chk("q1_left", q1.size(), 0);
        chk("q0_left", q0.size(), 0);
        chk("len1_left", len1.size(), 0);
        chk("len0_left", len0.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
